uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmit stage that produces the frame UART_Reciever consumes.
- Buffers bytes from the host logic in a small FIFO and serialises each one onto tx.
- Frame format: start 0, 8 data bits LSB first, parity, stop 1.
- Runs from the system clock. The bit period is a whole number of clocks, so at CLKS_PER_BIT=1 it drives UART_Reciever's rx directly.

Parameters:
- CLKS_PER_BIT, 1: clock cycles each serial bit is held (≥1).
- DEPTH, 4: FIFO entries (power of 2, ≥2).
- PARITY_ODD, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd (inverted).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe; one byte per cycle while high.
- tx  output  1  serial line; idles high.
- full  output  1  FIFO count == DEPTH (registered).
- busy  output  1  high when state != IDLE or FIFO count != 0.
- overflow  output  1  sticky; set when wr_en is seen while full. Cleared only by rst.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values (effective after the rst edge): tx=1, full=0, busy=0, overflow=0, FIFO count=0, pointers=0, state IDLE, bit counter=0, baud counter=0.
- Reset mid-frame: the frame is aborted and the FIFO is flushed. tx=1 from the next edge. No partial stop bit is emitted.
- FIFO write:
  - On an edge with wr_en=1 and full=0, data is stored and count increments.
  - wr_en while full: byte dropped, overflow<=1.
  - full is evaluated on the registered count. A write on the same edge as a pop while full is still rejected.
  - Simultaneous accepted write and pop: count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If count!=0, pop the head into an 8-bit shift register, compute parity from the popped byte, tx<=0, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then tx<=shift[0], bit index=0, go to DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, then shift right, tx<=next bit. After bit index 7 completes, tx<=parity, go to PARITY.
  - PARITY: held CLKS_PER_BIT cycles, then tx<=1, go to STOP.
  - STOP: held CLKS_PER_BIT cycles. At the end, if count!=0, pop the next byte immediately, tx<=0, go to START (no idle gap). Otherwise go to IDLE.
- Timing:
  - tx is a registered output.
  - Write accepted at edge N into an empty, idle block: start bit appears after edge N+1.
  - Frame length: exactly 11*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. With CLKS_PER_BIT=1 every cycle is a boundary.
- Parity bit: ^byte ^ PARITY_ODD.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.
- busy stays high through the last stop bit. It falls on the edge the FSM enters IDLE with count==0.

Test Plan:
- Single byte:
  - Stimulus: reset; CLKS_PER_BIT=1; write 0xA5 at edge 0.
  - Response: tx after edges 1..11 = 0,1,0,1,0,0,1,0,1,0,1 (parity 0). Then tx=1 and busy=0 after edge 12.
- Back-to-back:
  - Stimulus: write 0x01 then 0x80 on consecutive cycles.
  - Response: 22 contiguous bit times. Data bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1. Both parity bits 1. No idle cycle between stop and the second start.
- Overflow:
  - Stimulus: DEPTH=4; write 0x10..0x15 on 6 consecutive edges starting idle.
  - Response: full=1 after the 5th write; 6th byte (0x15) dropped; overflow=1 and stays 1. Frames 0x10..0x14 emitted in order. busy stays high until the last stop bit ends.
- Baud divider:
  - Stimulus: CLKS_PER_BIT=4; write 0x3C.
  - Response: each bit constant for exactly 4 cycles; frame 44 cycles; parity bit 0.
- Reset mid-frame:
  - Stimulus: pulse rst during DATA bit 3 of 0xFF, with a second byte queued.
  - Response: tx=1 on the next edge; FIFO empty; busy=0; overflow=0; no further start bit without a new write.
- Loopback:
  - Stimulus: tx wired to UART_Reciever rx at CLKS_PER_BIT=1; send 0x5A.
  - Response: receiver presents data=0x5A, sent=1, error=0.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit stage: a small byte FIFO feeding a start/8N/parity/stop serialiser.
// The bit period is CLKS_PER_BIT system clocks; back-to-back frames leave no idle gap.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned DEPTH        = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       wr_en,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, busy_q, overflow_q;
  logic            tx_q, tx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic            tick, pop, push;
  logic [7:0]      head;

  // Writes are gated by the registered full flag, so a write coinciding with a pop
  // while full is still dropped.
  assign push    = wr_en && !full_q;
  assign head    = mem_q[rd_ptr_q];
  assign tick    = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign count_d = count_q + CW'(push) - CW'(pop);

  assign tx       = tx_q;
  assign full     = full_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (count_q != '0) state_d = StStart;
      StStart:  if (tick) state_d = StData;
      StData:   if (tick && bit_q == 3'd7) state_d = StParity;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = (count_q != '0) ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath and line output next values
  always_comb begin
    tx_d     = tx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_d    = bit_q;
    baud_d   = tick ? '0 : baud_q + BW'(1);
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = (^head) ^ PARITY_ODD;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          tx_d  = shift_q[0];
          bit_d = 3'd0;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            tx_d = parity_q;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tick) tx_d = 1'b1;
      end
      StStop: begin
        if (tick) begin
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = (^head) ^ PARITY_ODD;
            tx_d     = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_q      <= '0;
      baud_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      busy_q   <= (state_d != StIdle) || (count_d != '0);
      if (wr_en && full_q) overflow_q <= 1'b1;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Drives two transmitters (1 and 4 clocks per bit) with identical stimulus and compares
// every cycle against a frame-level model built from byte queues and bit-sample queues.
module tb_uart_transmitter;

  localparam int unsigned Depth = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       wr_en;
  logic       tx1, full1, busy1, ovf1;
  logic       tx4, full4, busy4, ovf4;

  int n_cmp = 0;
  int n_err = 0;

  uart_transmitter #(.CLKS_PER_BIT(1), .DEPTH(Depth), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .data(data), .wr_en(wr_en),
    .tx(tx1), .full(full1), .busy(busy1), .overflow(ovf1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .DEPTH(Depth), .PARITY_ODD(1'b1)) dut4 (
    .clk(clk), .rst(rst), .data(data), .wr_en(wr_en),
    .tx(tx4), .full(full4), .busy(busy4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bytes waiting to be sent, and the per-cycle line samples still to appear.
  logic [7:0] m_fifo [2][$];
  logic       m_line [2][$];
  logic       m_tx   [2];
  logic       m_full [2];
  logic       m_busy [2];
  logic       m_ovf  [2];

  task automatic model_edge(input int k, input int unsigned cpb, input bit odd,
                            input logic w, input logic [7:0] d, input logic r);
    logic       pre_full;
    logic       sending;
    logic [7:0] b;
    logic [10:0] fr;
    if (r) begin
      m_fifo[k].delete();
      m_line[k].delete();
      m_tx[k] = 1'b1; m_full[k] = 1'b0; m_busy[k] = 1'b0; m_ovf[k] = 1'b0;
      return;
    end
    pre_full = m_full[k];
    sending  = 1'b0;
    if (m_line[k].size() == 0 && m_fifo[k].size() != 0) begin
      b = m_fifo[k].pop_front();
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[i+1] = b[i];
      fr[9]  = (^b) ^ odd;
      fr[10] = 1'b1;
      for (int j = 0; j < 11; j++)
        for (int c = 0; c < int'(cpb); c++) m_line[k].push_back(fr[j]);
    end
    if (m_line[k].size() != 0) begin
      m_tx[k] = m_line[k].pop_front();
      sending = 1'b1;
    end else begin
      m_tx[k] = 1'b1;
    end
    if (w) begin
      if (pre_full) m_ovf[k] = 1'b1;
      else m_fifo[k].push_back(d);
    end
    m_full[k] = (m_fifo[k].size() == Depth);
    m_busy[k] = sending || (m_fifo[k].size() != 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    data  = d;
    rst   = r;
    @(posedge clk);
    model_edge(0, 1, 1'b0, w, d, r);
    model_edge(1, 4, 1'b1, w, d, r);
    #1;
    chk("tx_cpb1",   tx1,   m_tx[0]);
    chk("full_cpb1", full1, m_full[0]);
    chk("busy_cpb1", busy1, m_busy[0]);
    chk("ovf_cpb1",  ovf1,  m_ovf[0]);
    chk("tx_cpb4",   tx4,   m_tx[1]);
    chk("full_cpb4", full4, m_full[1]);
    chk("busy_cpb4", busy4, m_busy[1]);
    chk("ovf_cpb4",  ovf4,  m_ovf[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [0:10] a5_seq;
    logic        w;
    logic [7:0]  d;
    logic        r;
    a5_seq = 11'b01010010101;
    wr_en = 1'b0; data = 8'h00; rst = 1'b1;

    // Reset state
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(3);

    // Single byte 0xA5, with the 1-clock line also held against the literal frame
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("a5_frame_tx", tx1, a5_seq[i]);
    end
    idle(50);

    // Back-to-back
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    idle(100);

    // Overflow: six writes into a four-entry FIFO
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    idle(240);

    // Divided bit period
    step(1'b1, 8'h3C, 1'b0);
    idle(50);

    // Reset during data bit 3 of 0xFF with a second byte queued
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    idle(4);
    step(1'b0, 8'h00, 1'b1);
    idle(60);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      w = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      r = ($urandom_range(0, 799) == 0);
      step(w, d, r);
    end
    idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
